adam_disk_client: RTL and testbench

- Initiator side of the per-drive sector-buffer interface (disk_load/disk_sector_loaded/disk_addr/disk_data/disk_wr/disk_flush) served by the drive's track loader.
- Turns one ADAM block request (read or write; 1 KB = SECTORS_PER_BLOCK x 512 B) from the AdamNet disk-device logic into a sequence of sector loads, byte streaming and flushes.
- Exposes valid/ready byte streams upstream.

---
 rtl/adam_disk_client.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_adam_disk_client.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adam_disk_client.sv
// rtl/adam_disk_client.sv - ADAM block request to sector-buffer sequencer (optional checksum: ADAM_DISK_CLIENT_CKSUM_EN)
module adam_disk_client #(
    parameter int SECTORS_PER_BLOCK = 2,
    parameter int LOAD_TIMEOUT      = 65535,
    parameter int FLUSH_GUARD       = 2048
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_block,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        done,
    output logic        error,
    output logic [7:0]  cksum,
    input  logic        disk_present,
    output logic [31:0] disk_sector,
    output logic        disk_load,
    input  logic        disk_sector_loaded,
    output logic [8:0]  disk_addr,
    output logic        disk_wr,
    output logic [7:0]  disk_din,
    input  logic [7:0]  disk_data,
    output logic        disk_flush,
    input  logic        disk_error
);

    localparam int SPB_SHIFT = $clog2(SECTORS_PER_BLOCK);
    localparam int TMAX      = (LOAD_TIMEOUT > FLUSH_GUARD) ? LOAD_TIMEOUT : FLUSH_GUARD;
    localparam int TW        = $clog2(TMAX + 1);

    // Load gives up after LOAD_TIMEOUT cycles of disk_load; guard spans the flush cycle plus FLUSH_GUARD quiet cycles
    localparam logic [TW-1:0] LOAD_LAST  = TW'(LOAD_TIMEOUT - 1);
    localparam logic [TW-1:0] GUARD_LAST = TW'(FLUSH_GUARD);
    localparam logic [3:0]    SEC_LAST   = 4'(SECTORS_PER_BLOCK - 1);
    localparam logic [8:0]    BYTE_LAST  = 9'd511;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RSTREAM,
        S_WFILL,
        S_FLUSH,
        S_GUARD,
        S_NEXT,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic [31:0]     sector_q, sector_d;
    logic [3:0]      sec_idx_q, sec_idx_d;
    logic [8:0]      addr_q, addr_d;
    logic [1:0]      ph_q, ph_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            req_ready_q, req_ready_d;
    logic            rd_valid_q, rd_valid_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            wr_ready_q, wr_ready_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            disk_load_q, disk_load_d;
    logic [8:0]      disk_addr_q, disk_addr_d;
    logic            disk_wr_q, disk_wr_d;
    logic [7:0]      disk_din_q, disk_din_d;
    logic            disk_flush_q, disk_flush_d;
    logic            abort;

    // Sequencer: next state plus the registered value of every output, derived from where the FSM is heading
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        sector_d     = sector_q;
        sec_idx_d    = sec_idx_q;
        addr_d       = addr_q;
        ph_d         = ph_q;
        timer_d      = timer_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        disk_addr_d  = disk_addr_q;
        disk_din_d   = disk_din_q;
        disk_wr_d    = 1'b0;
        disk_flush_d = 1'b0;
        done_d       = 1'b0;

        // Losing the image mid-transfer is handled exactly like a loader error
        abort = (state_q != S_IDLE) && (state_q != S_ERR) && (disk_error || !disk_present);

        if (abort) begin
            state_d = S_ERR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        write_d   = req_write;
                        sec_idx_d = 4'd0;
                        addr_d    = 9'd0;
                        ph_d      = 2'd0;
                        timer_d   = '0;
                        sector_d  = req_block << SPB_SHIFT;
                        if (!disk_present) begin
                            state_d = S_ERR;
                        end else if (req_write) begin
                            state_d = S_WFILL;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (disk_sector_loaded) begin
                        state_d     = S_RSTREAM;
                        addr_d      = 9'd0;
                        ph_d        = 2'd0;
                        disk_addr_d = 9'd0;
                    end else if (timer_q == LOAD_LAST) begin
                        state_d = S_ERR;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_RSTREAM: begin
                    // ph 0: address on the bus, ph 1: buffer data valid, ph 2: byte offered upstream
                    case (ph_q)
                        2'd0: ph_d = 2'd1;
                        2'd1: begin
                            rd_data_d  = disk_data;
                            rd_valid_d = 1'b1;
                            ph_d       = 2'd2;
                        end
                        default: begin
                            if (rd_ready) begin
                                ph_d = 2'd0;
                                if (addr_q == BYTE_LAST) begin
                                    state_d = S_NEXT;
                                end else begin
                                    addr_d      = addr_q + 1'b1;
                                    disk_addr_d = addr_q + 1'b1;
                                end
                            end else begin
                                rd_valid_d = 1'b1;
                            end
                        end
                    endcase
                end
                S_WFILL: begin
                    if (wr_valid && wr_ready_q) begin
                        disk_addr_d = addr_q;
                        disk_din_d  = wr_data;
                        disk_wr_d   = 1'b1;
                        if (addr_q == BYTE_LAST) begin
                            state_d = S_FLUSH;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Entered while the last byte write is on the bus; flush follows it
                    disk_flush_d = 1'b1;
                    timer_d      = '0;
                    state_d      = S_GUARD;
                end
                S_GUARD: begin
                    if (timer_q == GUARD_LAST) begin
                        state_d = S_NEXT;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (sec_idx_q == SEC_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        sec_idx_d = sec_idx_q + 1'b1;
                        sector_d  = sector_q + 32'd1;
                        addr_d    = 9'd0;
                        ph_d      = 2'd0;
                        timer_d   = '0;
                        state_d   = write_q ? S_WFILL : S_LOAD;
                    end
                end
                S_ERR: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        req_ready_d = (state_d == S_IDLE);
        wr_ready_d  = (state_d == S_WFILL);
        disk_load_d = (state_d == S_LOAD);
        error_d     = (state_d == S_ERR);
    end

    // State and output registers; reset abandons any transfer without flushing
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            sector_q     <= 32'd0;
            sec_idx_q    <= 4'd0;
            addr_q       <= 9'd0;
            ph_q         <= 2'd0;
            timer_q      <= '0;
            req_ready_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= 8'd0;
            wr_ready_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            disk_load_q  <= 1'b0;
            disk_addr_q  <= 9'd0;
            disk_wr_q    <= 1'b0;
            disk_din_q   <= 8'd0;
            disk_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            sector_q     <= sector_d;
            sec_idx_q    <= sec_idx_d;
            addr_q       <= addr_d;
            ph_q         <= ph_d;
            timer_q      <= timer_d;
            req_ready_q  <= req_ready_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            wr_ready_q   <= wr_ready_d;
            done_q       <= done_d;
            error_q      <= error_d;
            disk_load_q  <= disk_load_d;
            disk_addr_q  <= disk_addr_d;
            disk_wr_q    <= disk_wr_d;
            disk_din_q   <= disk_din_d;
            disk_flush_q <= disk_flush_d;
        end
    end

`ifdef ADAM_DISK_CLIENT_CKSUM_EN
    logic [7:0] cksum_q, cksum_d;

    // Running sum of every handshaken byte, restarted when a request is accepted
    always_comb begin
        cksum_d = cksum_q;
        if (state_q == S_IDLE && req_valid && req_ready_q) begin
            cksum_d = 8'd0;
        end else if (state_q == S_RSTREAM && rd_valid_q && rd_ready) begin
            cksum_d = cksum_q + rd_data_q;
        end else if (state_q == S_WFILL && wr_valid && wr_ready_q) begin
            cksum_d = cksum_q + wr_data;
        end
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cksum_q <= 8'd0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = 8'd0;
`endif

    assign req_ready   = req_ready_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign wr_ready    = wr_ready_q;
    assign done        = done_q;
    assign error       = error_q;
    assign disk_sector = sector_q;
    assign disk_load   = disk_load_q;
    assign disk_addr   = disk_addr_q;
    assign disk_wr     = disk_wr_q;
    assign disk_din    = disk_din_q;
    assign disk_flush  = disk_flush_q;

endmodule

// File: tb/tb_adam_disk_client.sv
// tb/tb_adam_disk_client.sv - scoreboard bench for adam_disk_client
`timescale 1ns/1ps
module tb_adam_disk_client;

    localparam int SPB = 2;
    localparam int LTO = 100;
    localparam int FG  = 16;
`ifdef ADAM_DISK_CLIENT_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_block = 32'd0;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_ready = 1'b1;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_ready;
    logic        done;
    logic        error;
    logic [7:0]  cksum;
    logic        disk_present = 1'b1;
    logic [31:0] disk_sector;
    logic        disk_load;
    logic        disk_sector_loaded = 1'b0;
    logic [8:0]  disk_addr;
    logic        disk_wr;
    logic [7:0]  disk_din;
    logic [7:0]  disk_data = 8'd0;
    logic        disk_flush;
    logic        disk_error = 1'b0;

    adam_disk_client #(
        .SECTORS_PER_BLOCK(SPB),
        .LOAD_TIMEOUT(LTO),
        .FLUSH_GUARD(FG)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_block(req_block),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .done(done), .error(error), .cksum(cksum),
        .disk_present(disk_present), .disk_sector(disk_sector), .disk_load(disk_load),
        .disk_sector_loaded(disk_sector_loaded), .disk_addr(disk_addr), .disk_wr(disk_wr),
        .disk_din(disk_din), .disk_data(disk_data), .disk_flush(disk_flush), .disk_error(disk_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_count = 0;
    int ends = 0;
    int pmode = 0;
    bit loader_en = 1'b1;
    bit rd_rand = 1'b0;

    logic [7:0]  exp_rd[$];
    logic [31:0] exp_load[$];
    logic [16:0] exp_wr[$];
    logic [31:0] exp_flush[$];
    int          exp_end[$];
    int          exp_end_cyc[$];
    logic [7:0]  exp_ck[$];

    logic [7:0] mem [512];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) disk_data <= mem[disk_addr];

    task automatic check(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Buffer contents the loader presents for a given sector
    function automatic logic [7:0] pat(input int mode, input logic [31:0] sec, input int a);
        case (mode)
            0:       return 8'(a);
            1:       return 8'h01;
            default: return 8'(sec * 37 + 32'(a) * 3 + 11);
        endcase
    endfunction

    // Loader model: answers disk_load after a short random delay with a freshly filled buffer
    initial begin
        forever begin
            @(negedge clk);
            if (loader_en && reset_n && disk_load) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (loader_en && reset_n && disk_load) begin
                    for (int a = 0; a < 512; a++) mem[a] = pat(pmode, disk_sector, a);
                    @(posedge clk); #1 disk_sector_loaded = 1'b1;
                    @(posedge clk); #1 disk_sector_loaded = 1'b0;
                    while (disk_load) @(negedge clk);
                end
            end
        end
    end

    // Upstream read backpressure
    initial begin
        forever begin
            @(posedge clk); #1;
            rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event
    initial begin
        bit prev_stall = 1'b0;
        bit prev_load = 1'b0;
        bit flush_seen = 1'b0;
        int flush_cyc = 0;
        logic [7:0] prev_data = 8'd0;
        logic [7:0] eb;
        logic [31:0] es;
        logic [16:0] ew;
        int ek, ec;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
                prev_load = 1'b0;
                flush_seen = 1'b0;
            end else begin
                if (rd_valid && wr_ready) check(1'b0, "rd_wr_exclusive", 1, 0);
                if (prev_stall) check(rd_valid && rd_data == prev_data, "rd_hold", {rd_valid, rd_data}, {1'b1, prev_data});
                if (rd_valid && rd_ready) begin
                    if (exp_rd.size() == 0) check(1'b0, "rd_extra", rd_data, 0);
                    else begin
                        eb = exp_rd.pop_front();
                        check(rd_data == eb, "rd_data", rd_data, eb);
                    end
                    rd_count++;
                end
                prev_stall = rd_valid && !rd_ready;
                prev_data = rd_data;

                if (flush_seen && (disk_wr || (disk_load && !prev_load) || done)) begin
                    check(cyc - flush_cyc > FG, "flush_guard", cyc - flush_cyc, FG + 1);
                    flush_seen = 1'b0;
                end
                if (disk_load && !prev_load) begin
                    if (exp_load.size() == 0) check(1'b0, "load_extra", disk_sector, 0);
                    else begin
                        es = exp_load.pop_front();
                        check(disk_sector == es, "load_sector", disk_sector, es);
                    end
                end
                prev_load = disk_load;
                if (disk_wr) begin
                    if (exp_wr.size() == 0) check(1'b0, "wr_extra", {disk_addr, disk_din}, 0);
                    else begin
                        ew = exp_wr.pop_front();
                        check({disk_addr, disk_din} == ew, "disk_write", {disk_addr, disk_din}, ew);
                    end
                end
                if (disk_flush) begin
                    if (exp_flush.size() == 0) check(1'b0, "flush_extra", disk_sector, 0);
                    else begin
                        es = exp_flush.pop_front();
                        check(disk_sector == es, "flush_sector", disk_sector, es);
                    end
                    flush_seen = 1'b1;
                    flush_cyc = cyc;
                end
                if (done || error) begin
                    check(!(done && error), "done_error_exclusive", {done, error}, 0);
                    if (exp_end.size() == 0) check(1'b0, "end_extra", {done, error}, 0);
                    else begin
                        ek = exp_end.pop_front();
                        ec = exp_end_cyc.pop_front();
                        check(ek == (done ? 1 : 2), "end_kind", done ? 1 : 2, ek);
                        if (ec >= 0) check(cyc == ec, "end_cycle", cyc, ec);
                        if (done && exp_ck.size() != 0) begin
                            eb = exp_ck.pop_front();
                            check(cksum == eb, "cksum", cksum, eb);
                        end
                        if (error) check(!disk_load && !disk_wr && !disk_flush, "error_strobes",
                                         {disk_load, disk_wr, disk_flush}, 0);
                    end
                    ends++;
                end
            end
        end
    end

    task automatic issue(input bit w, input logic [31:0] blk, output int acc);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) check(1'b0, "req_ready_timeout", n, 1000);
        req_valid = 1'b1;
        req_write = w;
        req_block = blk;
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_end(input int target);
        int n = 0;
        while (ends < target && n < 30000) begin @(negedge clk); n++; end
        check(ends >= target, "end_timeout", ends, target);
    endtask

    task automatic push_read(input logic [31:0] blk, input int mode);
        logic [7:0] s = 8'd0;
        logic [7:0] b;
        logic [31:0] sec;
        for (int k = 0; k < SPB; k++) begin
            sec = blk * 32'(SPB) + 32'(k);
            exp_load.push_back(sec);
            for (int a = 0; a < 512; a++) begin
                b = pat(mode, sec, a);
                exp_rd.push_back(b);
                s = s + b;
            end
        end
        exp_end.push_back(1);
        exp_end_cyc.push_back(-1);
        exp_ck.push_back(CK_EN ? s : 8'd0);
    endtask

    task automatic do_read(input logic [31:0] blk, input int mode, input bit rnd);
        int acc;
        int t = ends + 1;
        pmode = mode;
        rd_rand = rnd;
        push_read(blk, mode);
        issue(1'b0, blk, acc);
        wait_end(t);
        rd_rand = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] blk, input bit fixed);
        logic [7:0] data [1024];
        logic [7:0] s = 8'd0;
        int acc;
        int i = 0;
        int n = 0;
        bit hs;
        int t = ends + 1;
        for (int k = 0; k < 1024; k++) begin
            data[k] = fixed ? (8'(k) ^ 8'h5A) : 8'($urandom);
            exp_wr.push_back({9'(k % 512), data[k]});
            s = s + data[k];
        end
        for (int k = 0; k < SPB; k++) exp_flush.push_back(blk * 32'(SPB) + 32'(k));
        exp_end.push_back(1);
        exp_end_cyc.push_back(-1);
        exp_ck.push_back(CK_EN ? s : 8'd0);
        issue(1'b1, blk, acc);
        while (i < 1024 && n < 20000) begin
            wr_valid = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
            wr_data = data[i];
            @(negedge clk);
            hs = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (hs) i++;
            n++;
        end
        wr_valid = 1'b0;
        check(i == 1024, "write_feed", i, 1024);
        wait_end(t);
    endtask

    // Whole-model watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int t;
        logic [72:0] outs;
        for (int a = 0; a < 512; a++) mem[a] = 8'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {req_ready, rd_valid, rd_data, wr_ready, done, error, cksum, disk_sector,
                disk_load, disk_addr, disk_wr, disk_din, disk_flush};
        check(outs == '0, "reset_outputs", outs[63:0], 0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); @(negedge clk);
        outs = {req_ready, rd_valid, rd_data, wr_ready, done, error, cksum, disk_sector,
                disk_load, disk_addr, disk_wr, disk_din, disk_flush};
        check(outs == {1'b1, 72'd0}, "idle_after_reset", outs[63:0], 0);

        do_read(32'd5, 0, 1'b0);
        do_read(32'hFFFF_FFFF, 2, 1'b1);
        do_read(32'($urandom), 2, 1'b1);
        do_write(32'd3, 1'b1);
        do_write(32'($urandom), 1'b0);

        // No image mounted: immediate error, no load
        disk_present = 1'b0;
        t = ends + 1;
        issue(1'b0, 32'd9, acc);
        exp_end.push_back(2);
        exp_end_cyc.push_back(acc);
        wait_end(t);
        disk_present = 1'b1;

        // Loader never answers: error after LOAD_TIMEOUT cycles of disk_load
        loader_en = 1'b0;
        t = ends + 1;
        exp_load.push_back(32'd8);
        issue(1'b0, 32'd4, acc);
        exp_end.push_back(2);
        exp_end_cyc.push_back(acc + LTO);
        wait_end(t);
        loader_en = 1'b1;

        // Reset in the middle of a read stream
        pmode = 0;
        push_read(32'd12, 0);
        t = rd_count + 200;
        issue(1'b0, 32'd12, acc);
        acc = 0;
        while (rd_count < t && acc < 5000) begin @(negedge clk); acc++; end
        check(rd_count >= t, "reach_byte_200", rd_count, t);
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); @(negedge clk);
        outs = {req_ready, rd_valid, rd_data, wr_ready, done, error, cksum, disk_sector,
                disk_load, disk_addr, disk_wr, disk_din, disk_flush};
        check(outs == '0, "midstream_reset_outputs", outs[63:0], 0);
        exp_rd.delete(); exp_load.delete(); exp_end.delete(); exp_end_cyc.delete(); exp_ck.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check(req_ready == 1'b1, "req_ready_after_release", req_ready, 1);
        do_read(32'd7, 2, 1'b1);

        // All-0x01 block: checksum wraps to 0
        do_read(32'd20, 1, 1'b0);

        repeat (5) @(negedge clk);
        check(exp_rd.size() == 0, "rd_queue_drained", exp_rd.size(), 0);
        check(exp_load.size() == 0, "load_queue_drained", exp_load.size(), 0);
        check(exp_wr.size() == 0, "wr_queue_drained", exp_wr.size(), 0);
        check(exp_flush.size() == 0, "flush_queue_drained", exp_flush.size(), 0);
        check(exp_end.size() == 0, "end_queue_drained", exp_end.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
